// File: rtl/write_post_buffer_pkg.sv
// Shared bus definitions for the CPU write path: byte-lane indices and enable constants.
package write_post_buffer_pkg;

    localparam int LANE_HH = 3;
    localparam int LANE_HL = 2;
    localparam int LANE_LH = 1;
    localparam int LANE_LL = 0;
    localparam int LANE_W  = 8;
    localparam int NUM_LANES = LANE_HH + 1;

    localparam logic [NUM_LANES-1:0] BE_LONG = 4'b1111;

    typedef logic [NUM_LANES-1:0]        be_t;
    typedef logic [NUM_LANES*LANE_W-1:0] data_t;

endpackage

// File: rtl/write_post_buffer_if.sv
// CPU-side write port, memory-side drain port and read-hazard probe of the posted-write buffer.
interface write_post_buffer_if #(
    parameter int ADDR_W = 22
);
    logic              WR_REQ;
    logic              WR_RDY;
    logic [ADDR_W-1:0] WR_ADDR;
    logic [3:0]        WR_BE;
    logic [31:0]       WR_DATA;

    logic              MEM_REQ;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [3:0]        MEM_BE;
    logic [31:0]       MEM_DATA;
    logic              MEM_ACK;

    logic [ADDR_W-1:0] RD_ADDR;
    logic              RD_HAZ;
    logic              EMPTY;

    modport slave (
        input  WR_REQ, WR_ADDR, WR_BE, WR_DATA, MEM_ACK, RD_ADDR,
        output WR_RDY, MEM_REQ, MEM_ADDR, MEM_BE, MEM_DATA, RD_HAZ, EMPTY
    );

    modport master (
        output WR_REQ, WR_ADDR, WR_BE, WR_DATA, MEM_ACK, RD_ADDR,
        input  WR_RDY, MEM_REQ, MEM_ADDR, MEM_BE, MEM_DATA, RD_HAZ, EMPTY
    );
endinterface

// File: rtl/write_post_buffer_be_merge.sv
// Byte-lane merge: lanes enabled in new_be take new_data, all others keep old_data.
module write_post_buffer_be_merge
    import write_post_buffer_pkg::*;
(
    input  be_t   old_be,
    input  data_t old_data,
    input  be_t   new_be,
    input  data_t new_data,
    output be_t   merged_be,
    output data_t merged_data
);

    assign merged_be = old_be | new_be;

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            assign merged_data[gi*LANE_W +: LANE_W] = new_be[gi] ? new_data[gi*LANE_W +: LANE_W]
                                                                 : old_data[gi*LANE_W +: LANE_W];
        end
    endgenerate

endmodule

// File: rtl/write_post_buffer.sv
// Posted-write FIFO between the CPU and memory controller; coalesces consecutive
// writes to the same longword into the tail entry.
module write_post_buffer
    import write_post_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 22
) (
    input  logic                 CLK,
    input  logic                 RST,
    write_post_buffer_if.slave   bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    be_t               be_q   [DEPTH];
    be_t               be_d   [DEPTH];
    data_t             data_q [DEPTH];
    data_t             data_d [DEPTH];
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [PTR_W-1:0]  tail_m1;
    logic              merge_hit, wr_rdy, push, do_merge, do_alloc, pop;
    be_t               merge_be, alloc_be;
    data_t             merge_data, alloc_data;
    logic [DEPTH-1:0]  haz_hit;

    assign tail_m1   = tail_q - PTR_W'(1);
    // The head may already be on the memory bus, so only a second-or-later entry is a merge target.
    assign merge_hit = (count_q >= CNT_W'(2)) && (bus.WR_ADDR == addr_q[tail_m1]);
    assign wr_rdy    = (count_q < DEPTH_C) || merge_hit;
    assign push      = bus.WR_REQ && wr_rdy && (bus.WR_BE != 4'b0000);
    assign do_merge  = push && merge_hit;
    assign do_alloc  = push && !merge_hit;
    assign pop       = bus.MEM_ACK && (count_q != '0);

    write_post_buffer_be_merge u_merge (
        .old_be      (be_q[tail_m1]),
        .old_data    (data_q[tail_m1]),
        .new_be      (bus.WR_BE),
        .new_data    (bus.WR_DATA),
        .merged_be   (merge_be),
        .merged_data (merge_data)
    );

    // Zero-fills disabled lanes of a freshly allocated entry.
    write_post_buffer_be_merge u_alloc (
        .old_be      ('0),
        .old_data    ('0),
        .new_be      (bus.WR_BE),
        .new_data    (bus.WR_DATA),
        .merged_be   (alloc_be),
        .merged_data (alloc_data)
    );

    always_comb begin
        addr_d  = addr_q;
        be_d    = be_q;
        data_d  = data_q;
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end
        if (do_merge) begin
            be_d[tail_m1]   = merge_be;
            data_d[tail_m1] = merge_data;
        end
        if (do_alloc) begin
            addr_d[tail_q]  = bus.WR_ADDR;
            be_d[tail_q]    = alloc_be;
            data_d[tail_q]  = alloc_data;
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PTR_W'(1);
        end
        case ({do_alloc, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                be_q[i]   <= '0;
                data_q[i] <= '0;
            end
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            addr_q  <= addr_d;
            be_q    <= be_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_haz
            assign haz_hit[gi] = valid_q[gi] && (addr_q[gi] == bus.RD_ADDR);
        end
    endgenerate

    assign bus.WR_RDY   = wr_rdy;
    assign bus.MEM_REQ  = (count_q != '0);
    assign bus.MEM_ADDR = (count_q != '0) ? addr_q[head_q] : '0;
    assign bus.MEM_BE   = (count_q != '0) ? be_q[head_q]   : '0;
    assign bus.MEM_DATA = (count_q != '0) ? data_q[head_q] : '0;
    assign bus.RD_HAZ   = |haz_hit;
    assign bus.EMPTY    = (count_q == '0);

endmodule

// File: tb/tb_write_post_buffer.sv
// Scoreboard bench for write_post_buffer: a queue model of the FIFO predicts every drain.
module tb_write_post_buffer;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 22;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [3:0]        be;
        logic [31:0]       data;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    int   acks_seen = 0;
    ent_t mq[$];

    write_post_buffer_if #(.ADDR_W(ADDR_W)) bus ();

    write_post_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic post_check(input string tag);
        n_vec++;
        if (bus.EMPTY !== (mq.size() == 0)) begin
            n_err++;
            $display("FAIL %s empty: got %b want %b", tag, bus.EMPTY, mq.size() == 0);
        end
        n_vec++;
        if (bus.MEM_REQ !== (mq.size() != 0)) begin
            n_err++;
            $display("FAIL %s mem_req: got %b want %b", tag, bus.MEM_REQ, mq.size() != 0);
        end
        n_vec++;
        if (32'(dut.count_q) !== mq.size()) begin
            n_err++;
            $display("FAIL %s count: got %0d want %0d", tag, dut.count_q, mq.size());
        end
        if (mq.size() != 0) begin
            n_vec++;
            if ({bus.MEM_ADDR, bus.MEM_BE, bus.MEM_DATA} !== mq[0]) begin
                n_err++;
                $display("FAIL %s head: got %h/%b/%h want %h/%b/%h", tag, bus.MEM_ADDR, bus.MEM_BE,
                         bus.MEM_DATA, mq[0].addr, mq[0].be, mq[0].data);
            end
        end
    endtask

    // One clock of stimulus, entered and left just after a falling edge.
    task automatic cycle(input logic req, input logic [ADDR_W-1:0] a, input logic [3:0] be,
                         input logic [31:0] d, input logic ack, input string tag);
        bit   merge, exp_rdy;
        ent_t e;
        bus.WR_REQ  = req;
        bus.WR_ADDR = a;
        bus.WR_BE   = be;
        bus.WR_DATA = d;
        bus.MEM_ACK = ack;
        #1;
        merge   = (mq.size() >= 2) && (mq[mq.size()-1].addr == a);
        exp_rdy = (mq.size() < DEPTH) || merge;
        n_vec++;
        if (bus.WR_RDY !== exp_rdy) begin
            n_err++;
            $display("FAIL %s wr_rdy: got %b want %b", tag, bus.WR_RDY, exp_rdy);
        end
        @(posedge clk);
        if (req && exp_rdy && be != 4'b0000) begin
            if (merge) begin
                e = mq[mq.size()-1];
                for (int i = 0; i < 4; i++)
                    if (be[i]) e.data[i*8 +: 8] = d[i*8 +: 8];
                e.be = e.be | be;
                mq[mq.size()-1] = e;
            end else begin
                e.addr = a;
                e.be   = be;
                e.data = '0;
                for (int i = 0; i < 4; i++)
                    if (be[i]) e.data[i*8 +: 8] = d[i*8 +: 8];
                mq.push_back(e);
            end
        end
        if (ack && mq.size() != 0) begin
            void'(mq.pop_front());
            acks_seen++;
        end
        @(negedge clk);
        bus.WR_REQ  = 1'b0;
        bus.MEM_ACK = 1'b0;
        post_check(tag);
        $display("txn %-10s req=%b addr=%h be=%b data=%h ack=%b rdy=%b depth=%0d",
                 tag, req, a, be, d, ack, exp_rdy, mq.size());
    endtask

    task automatic drain_all(input string tag);
        while (mq.size() != 0) cycle(1'b0, '0, 4'b0000, 32'h0, 1'b1, tag);
    endtask

    task automatic check_haz(input logic [ADDR_W-1:0] a, input logic want, input string tag);
        bus.RD_ADDR = a;
        #1;
        n_vec++;
        if (bus.RD_HAZ !== want) begin
            n_err++;
            $display("FAIL %s rd_haz @%h: got %b want %b", tag, a, bus.RD_HAZ, want);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({bus.MEM_REQ, bus.EMPTY, bus.WR_RDY, bus.RD_HAZ} !== 4'b0110) begin
            n_err++;
            $display("FAIL reset flags: got %b want 0110",
                     {bus.MEM_REQ, bus.EMPTY, bus.WR_RDY, bus.RD_HAZ});
        end
        n_vec++;
        if ({bus.MEM_ADDR, bus.MEM_BE, bus.MEM_DATA} !== '0) begin
            n_err++;
            $display("FAIL reset mem_bus: got %h/%b/%h want 0", bus.MEM_ADDR, bus.MEM_BE, bus.MEM_DATA);
        end
        rst = 1'b0;
        @(negedge clk);
        post_check("reset");
    endtask

    task automatic test_single();
        cycle(1'b1, 22'h000040, write_post_buffer_pkg::BE_LONG, 32'h11223344, 1'b0, "t1_push");
        n_vec++;
        if ({bus.MEM_REQ, bus.MEM_ADDR, bus.MEM_BE, bus.MEM_DATA} !== {1'b1, 22'h000040, 4'b1111, 32'h11223344}) begin
            n_err++;
            $display("FAIL t1 head: got %b %h %b %h want 1 000040 1111 11223344",
                     bus.MEM_REQ, bus.MEM_ADDR, bus.MEM_BE, bus.MEM_DATA);
        end
        cycle(1'b0, '0, 4'b0000, 32'h0, 1'b1, "t1_ack");
        cycle(1'b0, '0, 4'b0000, 32'h0, 1'b1, "t1_idleack");
        cycle(1'b1, 22'h000077, 4'b0000, 32'hDEADBEEF, 1'b0, "t1_be0");
        cycle(1'b1, 22'h000041, 4'b0110, 32'hCAFEF00D, 1'b0, "t1_zfill");
        drain_all("t1_drain");
    endtask

    task automatic test_merge();
        int acks0 = acks_seen;
        cycle(1'b1, 22'h000100, 4'b1111, 32'h01020304, 1'b0, "t2_a");
        cycle(1'b1, 22'h000200, 4'b1000, 32'hAA000000, 1'b0, "t2_b");
        cycle(1'b1, 22'h000200, 4'b0001, 32'h000000BB, 1'b0, "t2_merge");
        cycle(1'b0, '0, 4'b0000, 32'h0, 1'b1, "t2_ack1");
        n_vec++;
        if ({bus.MEM_ADDR, bus.MEM_BE, bus.MEM_DATA} !== {22'h000200, 4'b1001, 32'hAA0000BB}) begin
            n_err++;
            $display("FAIL t2 merged: got %h/%b/%h want 000200/1001/aa0000bb",
                     bus.MEM_ADDR, bus.MEM_BE, bus.MEM_DATA);
        end
        cycle(1'b0, '0, 4'b0000, 32'h0, 1'b1, "t2_ack2");
        n_vec++;
        if (acks_seen - acks0 !== 2 || bus.EMPTY !== 1'b1) begin
            n_err++;
            $display("FAIL t2 writes: got %0d empty=%b want 2 empty=1", acks_seen - acks0, bus.EMPTY);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 22'h000010 + 22'(i), 4'b1111, 32'h10000000 + 32'(i), 1'b0, "t3_fill");
        cycle(1'b1, 22'h000020, 4'b1111, 32'h20202020, 1'b0, "t3_reject");
        cycle(1'b1, 22'h000013, 4'b0010, 32'h0000EE00, 1'b0, "t3_mergef");
        drain_all("t3_drain");
    endtask

    task automatic test_full_ack();
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 22'h000030 + 22'(i), 4'b1111, 32'h30000000 + 32'(i), 1'b0, "t4_fill");
        cycle(1'b1, 22'h000050, 4'b1111, 32'h55555555, 1'b1, "t4_rejack");
        cycle(1'b1, 22'h000050, 4'b1111, 32'h55555555, 1'b0, "t4_accept");
        cycle(1'b1, 22'h000050, 4'b0100, 32'h00990000, 1'b1, "t4_mrgpop");
        drain_all("t4_drain");
    endtask

    task automatic test_hazard();
        cycle(1'b1, 22'h000300, 4'b1111, 32'h33333333, 1'b0, "t5_a");
        cycle(1'b1, 22'h000304, 4'b1111, 32'h44444444, 1'b0, "t5_b");
        check_haz(22'h000304, 1'b1, "t5_hit");
        check_haz(22'h000308, 1'b0, "t5_miss");
        drain_all("t5_drain");
        check_haz(22'h000304, 1'b0, "t5_drained");
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 22'h000400 + 22'(i), 4'b1111, 32'h40000000 + 32'(i), 1'b0, "t6_fill");
        #2 rst = 1'b1;
        #1;
        mq.delete();
        n_vec++;
        if (bus.MEM_REQ !== 1'b0 || bus.EMPTY !== 1'b1) begin
            n_err++;
            $display("FAIL t6 async: got req=%b empty=%b want 0 1", bus.MEM_REQ, bus.EMPTY);
        end
        bus.MEM_ACK = 1'b1;
        repeat (2) begin
            @(negedge clk);
            n_vec++;
            if (bus.MEM_REQ !== 1'b0) begin
                n_err++;
                $display("FAIL t6 held: got mem_req=%b want 0", bus.MEM_REQ);
            end
        end
        bus.MEM_ACK = 1'b0;
        rst = 1'b0;
        cycle(1'b1, 22'h000500, 4'b0011, 32'h12345678, 1'b0, "t6_new");
        drain_all("t6_drain");
    endtask

    initial begin
        bus.WR_REQ  = 1'b0;
        bus.WR_ADDR = '0;
        bus.WR_BE   = '0;
        bus.WR_DATA = '0;
        bus.MEM_ACK = 1'b0;
        bus.RD_ADDR = '0;
        test_reset();
        test_single();
        test_merge();
        test_full();
        test_full_ack();
        test_hazard();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
